lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
Load/store unit sitting directly downstream of the ALU in the RISC-V core. It takes the effective address computed by the ALU plus rs2 store data and funct3, and runs one data-memory transaction over a req/ack handshake. It applies byte-lane steering and write strobes for stores, and lane extraction with sign/zero extension for loads. It reports completion, writeback data and faults to the writeback stage; one transaction is in flight at a time.

Parameters:
TIMEOUT, 16, max cycles in REQ waiting for mem_ack before abort; 0 disables timeout.
CNT_W, 8, width of timeout counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous active-low reset: state cleared on a rising clk edge while reset==0
start  input  1  request valid; accepted only when ready==1
ready  output  1  1 in IDLE only
opcode  input  7  instruction opcode; [6:2]==5'b00000 load, 5'b01000 store, anything else illegal
funct3  input  3  width/sign select (LB/LH/LW/LBU/LHU, SB/SH/SW)
addr  input  32  effective byte address (ALU out)
wdata  input  32  store data (rs2)
rd  input  5  destination register for loads
mem_req  output  1  memory request, held until ack or abort
mem_we  output  1  1 = write
mem_addr  output  32  word address: {addr[31:2],2'b00}
mem_wstrb  output  4  byte write enables (0 for loads)
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  read word, valid when mem_ack==1
mem_ack  input  1  transaction complete
done  output  1  one-cycle completion pulse
wb_en  output  1  with done: load completed without fault
rd_out  output  5  rd of completed op (valid with done)
rdata  output  32  extended load result (valid with done and wb_en)
err  output  2  with done: 00 ok, 01 misaligned, 10 illegal, 11 timeout

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE; mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, done=0, wb_en=0, err=0, rdata=0, rd_out=0, counter=0. Applies mid-transaction: request dropped; any later mem_ack outside REQ is ignored.
- FSM states: IDLE, REQ, RESP.
- IDLE: ready=1. On start==1, register opcode/funct3/addr/wdata/rd and classify:
  - illegal (opcode class not load/store; load funct3 in {3,6,7}; store funct3>2) -> RESP, err=10.
  - misaligned (H: addr[0]!=0; W: addr[1:0]!=0) -> RESP, err=01, no mem_req.
  - otherwise -> REQ; mem_req=1 from the next cycle; mem_addr, mem_we, mem_wstrb, mem_wdata registered and stable throughout REQ.
- Store steering: SB wstrb=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; SH wstrb=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}; SW wstrb=4'b1111, wdata unchanged. Loads: wstrb=0, mem_we=0.
- REQ: counter increments each cycle. On mem_ack==1: capture mem_rdata, drop mem_req the next cycle, -> RESP, err=00. If TIMEOUT!=0 and counter==TIMEOUT-1 with no ack: drop mem_req, -> RESP, err=11. Ack in the same cycle as the timeout tick takes priority (success).
- Load extraction: byte = mem_rdata[8*addr[1:0] +: 8], half = mem_rdata[16*addr[1] +: 16]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
- RESP: done=1 for exactly one cycle; wb_en=1 only for fault-free loads; rdata=0 when wb_en==0; rd_out=registered rd; -> IDLE. done/wb_en/err return to 0 the following cycle.
- Latency: start at cycle 0 -> mem_req high in cycle 1; ack sampled in cycle k -> done in cycle k+1. Faults without a request: done in cycle 1.
- start while ready==0 is ignored (not queued). Back-to-back: start may be asserted in the cycle after done (IDLE).

Test Plan:
- LW addr=0x1004, ack on 3rd REQ cycle, mem_rdata=0xDEADBEEF -> mem_addr=0x1004, wstrb=0, done 1 cycle after ack, wb_en=1, rdata=0xDEADBEEF, err=00.
- LB addr=0x1003, mem_rdata=0x80FF_0000 -> rdata=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x1002 -> 0xFFFF80FF; LHU -> 0x000080FF.
- SB addr=0x2002 wdata=0x123456AB -> mem_we=1, wstrb=0100, mem_wdata=0xABABABAB, mem_addr=0x2000; SH addr=0x2002 -> wstrb=1100, wdata=0x56AB56AB; done wb_en=0.
- LW addr=0x1001 -> no mem_req, done in cycle 1, err=01, wb_en=0; opcode=0x33 -> err=10; load funct3=3 -> err=10.
- TIMEOUT=16, never ack -> mem_req high exactly 16 cycles, then done with err=11; a late mem_ack in IDLE produces no done.
- reset=0 asserted in 2nd REQ cycle -> next edge: mem_req=0, ready=1, no done; start with a mid-REQ start pulse while busy is ignored.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: accepts one load or store from the ALU and runs it
// over a req/ack data-memory handshake. Stores get byte-lane steering and write
// strobes. Loads get lane extraction with sign or zero extension. One
// transaction is in flight at a time. Completion is a one-cycle done pulse with
// an error code.
module lsu_mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        done,
    output logic        wb_en,
    output logic [4:0]  rd_out,
    output logic [31:0] rdata,
    output logic [1:0]  err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam bit             TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              wb_en_q, wb_en_d;
    logic [1:0]        err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic              is_load_q, is_load_d;

    // Opcode bits [1:0] do not take part in classification.
    logic unused_opcode_lo;
    assign unused_opcode_lo = ^opcode[1:0];

    logic        dec_load, dec_store, dec_illegal, dec_misaligned;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_result;

    // Classify the incoming request and build the steered store lanes.
    always_comb begin
        dec_load    = (opcode[6:2] == 5'b00000);
        dec_store   = (opcode[6:2] == 5'b01000);
        dec_illegal = !((dec_load && (funct3 != 3'd3) && (funct3 != 3'd6) && (funct3 != 3'd7)) ||
                        (dec_store && (funct3 <= 3'd2)));
        dec_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        st_strb = 4'b1111;
        st_data = wdata;
        case (funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_strb = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed lane from the returned word and extend it.
    always_comb begin
        case (addr_lo_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q[1:0])
            2'b00:   ld_result = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_result = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
            default: ld_result = mem_rdata;
        endcase
    end

    // Next-state and next-output logic for the IDLE/REQ/RESP controller.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        addr_lo_d   = addr_lo_q;
        is_load_d   = is_load_q;
        done_d      = 1'b0;
        wb_en_d     = 1'b0;
        err_d       = 2'b00;
        rdata_d     = 32'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_d      = rd;
                    f3_d      = funct3;
                    addr_lo_d = addr[1:0];
                    is_load_d = dec_load;
                    if (dec_illegal) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 2'b10;
                    end else if (dec_misaligned) begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 2'b01;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = dec_store;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_wstrb_d = dec_store ? st_strb : 4'b0000;
                        mem_wdata_d = dec_store ? st_data : 32'd0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                // An ack on the timeout tick still counts as success.
                if (mem_ack) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    done_d      = 1'b1;
                    wb_en_d     = is_load_q;
                    rdata_d     = is_load_q ? ld_result : 32'd0;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    done_d      = 1'b1;
                    err_d       = 2'b11;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'd0;
            done_q      <= 1'b0;
            wb_en_q     <= 1'b0;
            err_q       <= 2'b00;
            rdata_q     <= 32'd0;
            rd_q        <= 5'd0;
            cnt_q       <= '0;
            f3_q        <= 3'd0;
            addr_lo_q   <= 2'd0;
            is_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            wb_en_q     <= wb_en_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            addr_lo_q   <= addr_lo_d;
            is_load_q   <= is_load_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign wb_en     = wb_en_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign rd_out    = rd_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed test-plan items, then random transactions
// checked against a byte-level reference model of the load/store rules.
module tb_lsu_mem_stage;

    localparam int TO = 16;

    logic        clk;
    logic        reset;
    logic        start;
    logic        ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        done;
    logic        wb_en;
    logic [4:0]  rd_out;
    logic [31:0] rdata;
    logic [1:0]  err;

    int n_checks = 0;
    int n_fail   = 0;

    lsu_mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ready     (ready),
        .opcode    (opcode),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rd        (rd),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .done      (done),
        .wb_en     (wb_en),
        .rd_out    (rd_out),
        .rdata     (rdata),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no end of test, expected end within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: derives the outcome from access size in bytes and byte offsets.
    function automatic void model(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] md,
                                  output logic [1:0] e, output logic [3:0] strb,
                                  output logic [31:0] mwd, output logic [31:0] res,
                                  output bit ld);
        bit st, legal;
        int nbytes, off;
        longint val, mask;
        ld = (opc[6:2] == 5'd0);
        st = (opc[6:2] == 5'd8);
        legal = ld ? !(f3 == 3 || f3 == 6 || f3 == 7) : (st ? (f3 <= 2) : 1'b0);
        nbytes = (f3[1:0] == 0) ? 1 : ((f3[1:0] == 1) ? 2 : 4);
        off = int'(a[1:0]);
        if (!legal)                e = 2'b10;
        else if (off % nbytes != 0) e = 2'b01;
        else                        e = 2'b00;
        strb = st ? 4'(((1 << nbytes) - 1) << off) : 4'b0000;
        mwd = 32'd0;
        for (int i = 0; i < 4; i++) begin
            mwd = mwd | (32'((wd >> (8 * (i % nbytes))) & 32'hFF) << (8 * i));
        end
        mask = (longint'(1) << (8 * nbytes)) - 1;
        val = (longint'(md) >> (8 * off)) & mask;
        if (f3[2] == 1'b0 && nbytes < 4 && val >= (mask + 1) / 2) val = val - (mask + 1);
        res = 32'(val);
    endfunction

    // One transaction from IDLE; ack_at = REQ cycle (1-based) carrying mem_ack, 0 = never.
    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] r, input int ack_at,
                          input logic [31:0] md, input bit poke_busy);
        logic [1:0]  e, exp_err;
        logic [3:0]  strb;
        logic [31:0] mwd, res;
        bit          ld, exp_wb;
        model(opc, f3, a, wd, md, e, strb, mwd, res, ld);
        check("ready_idle", 32'(ready), 32'd1);
        opcode = opc; funct3 = f3; addr = a; wdata = wd; rd = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0; opcode = 7'h33; funct3 = ~f3; addr = ~a; wdata = ~wd; rd = ~r;
        if (e != 2'b00) begin
            check("fault_done", 32'(done), 32'd1);
            check("fault_err", 32'(err), 32'(e));
            check("fault_wb_en", 32'(wb_en), 32'd0);
            check("fault_no_req", 32'(mem_req), 32'd0);
            check("fault_rd_out", 32'(rd_out), 32'(r));
        end else begin
            for (int i = 1; i <= TO; i++) begin
                check("req_high", 32'(mem_req), 32'd1);
                check("req_addr", mem_addr, {a[31:2], 2'b00});
                check("req_we", 32'(mem_we), 32'(!ld));
                check("req_wstrb", 32'(mem_wstrb), 32'(strb));
                if (!ld) check("req_wdata", mem_wdata, mwd);
                check("req_no_done", 32'(done), 32'd0);
                check("req_not_ready", 32'(ready), 32'd0);
                if (poke_busy && i == 1) begin
                    start = 1'b1; opcode = 7'h23; funct3 = 3'd2; addr = 32'h0000_4000;
                end
                if (i == ack_at) begin
                    mem_ack = 1'b1;
                    mem_rdata = md;
                end
                @(negedge clk);
                start = 1'b0;
                mem_ack = 1'b0;
                mem_rdata = $urandom;
                if (i == ack_at) break;
            end
            exp_err = (ack_at >= 1 && ack_at <= TO) ? 2'b00 : 2'b11;
            exp_wb = ld && (exp_err == 2'b00);
            check("resp_done", 32'(done), 32'd1);
            check("resp_err", 32'(err), 32'(exp_err));
            check("resp_req_low", 32'(mem_req), 32'd0);
            check("resp_wb_en", 32'(wb_en), 32'(exp_wb));
            check("resp_rdata", rdata, exp_wb ? res : 32'd0);
            check("resp_rd_out", 32'(rd_out), 32'(r));
        end
        @(negedge clk);
        check("after_done", 32'(done), 32'd0);
        check("after_wb_en", 32'(wb_en), 32'd0);
        check("after_err", 32'(err), 32'd0);
        check("after_ready", 32'(ready), 32'd1);
        check("after_req", 32'(mem_req), 32'd0);
    endtask

    // Directed steps followed by random transactions.
    initial begin
        logic [6:0]  r_opc;
        logic [2:0]  r_f3;
        int          kind, sel, ack_at;
        reset = 1'b0; start = 1'b0; opcode = '0; funct3 = '0; addr = '0; wdata = '0;
        rd = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // Loads with lane extraction.
        run_op(7'h03, 3'd2, 32'h0000_1004, 32'd0, 5'd7, 3, 32'hDEAD_BEEF, 1'b0);
        run_op(7'h03, 3'd0, 32'h0000_1003, 32'd0, 5'd8, 1, 32'h80FF_0000, 1'b0);
        run_op(7'h03, 3'd4, 32'h0000_1003, 32'd0, 5'd9, 2, 32'h80FF_0000, 1'b0);
        run_op(7'h03, 3'd1, 32'h0000_1002, 32'd0, 5'd10, 1, 32'h80FF_0000, 1'b0);
        run_op(7'h03, 3'd5, 32'h0000_1002, 32'd0, 5'd11, 4, 32'h80FF_0000, 1'b0);
        // Stores with steering.
        run_op(7'h23, 3'd0, 32'h0000_2002, 32'h1234_56AB, 5'd1, 2, 32'd0, 1'b0);
        run_op(7'h23, 3'd1, 32'h0000_2002, 32'h1234_56AB, 5'd2, 1, 32'd0, 1'b0);
        run_op(7'h23, 3'd2, 32'h0000_2000, 32'h1234_56AB, 5'd3, 5, 32'd0, 1'b0);
        // Faults without a request.
        run_op(7'h03, 3'd2, 32'h0000_1001, 32'd0, 5'd4, 1, 32'd0, 1'b0);
        run_op(7'h33, 3'd0, 32'h0000_1000, 32'd0, 5'd5, 1, 32'd0, 1'b0);
        run_op(7'h03, 3'd3, 32'h0000_1000, 32'd0, 5'd6, 1, 32'd0, 1'b0);
        run_op(7'h23, 3'd4, 32'h0000_1000, 32'd0, 5'd6, 1, 32'd0, 1'b0);
        // Ack on the last allowed cycle wins over the timeout.
        run_op(7'h03, 3'd2, 32'h0000_1008, 32'd0, 5'd12, TO, 32'h1357_9BDF, 1'b0);
        // Timeout, then a late ack in IDLE must not produce done.
        run_op(7'h03, 3'd2, 32'h0000_1008, 32'd0, 5'd13, 0, 32'd0, 1'b0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check("late_ack_no_done2", 32'(done), 32'd0);
        check("late_ack_ready", 32'(ready), 32'd1);
        // Start while busy is ignored.
        run_op(7'h03, 3'd2, 32'h0000_100C, 32'd0, 5'd14, 3, 32'hCAFE_F00D, 1'b1);
        check("busy_start_ignored", 32'(mem_req), 32'd0);

        // Reset in the 2nd REQ cycle.
        opcode = 7'h03; funct3 = 3'd2; addr = 32'h0000_3000; rd = 5'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rstmid_req1", 32'(mem_req), 32'd1);
        @(negedge clk);
        check("rstmid_req2", 32'(mem_req), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rstmid_req_low", 32'(mem_req), 32'd0);
        check("rstmid_ready", 32'(ready), 32'd1);
        check("rstmid_no_done", 32'(done), 32'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("rstmid_ack_no_done", 32'(done), 32'd0);
        @(negedge clk);
        check("rstmid_ack_no_done2", 32'(done), 32'd0);
        check("rstmid_ready2", 32'(ready), 32'd1);

        // Random transactions.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            r_f3 = 3'($urandom_range(0, 7));
            if (kind <= 4) begin
                r_opc = 7'h03;
            end else if (kind <= 8) begin
                r_opc = 7'h23;
                if (kind != 8) r_f3 = 3'($urandom_range(0, 2));
            end else begin
                sel = $urandom_range(1, 30);
                if (sel >= 8) sel++;
                r_opc = {5'(sel), 2'(($urandom_range(0, 3)))};
            end
            ack_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            run_op(r_opc, r_f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                   ack_at, $urandom, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
